bcd_serial_addsub: RTL and testbench

Digit-serial sequencer for multi-digit packed-BCD addition and subtraction. It accepts two DIGITS-wide BCD operands and an add/sub select over a valid/ready handshake. It then drives one shared single-digit BCD adder stage once per clock, least-significant digit first, and presents the packed result with a decimal carry/no-borrow flag over a second valid/ready handshake. It sits in the BCD arithmetic datapath as the controller that time-multiplexes one digit adder across all operand positions.

---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_digit_stage.sv | 17 +
 rtl/bcd_serial_addsub.sv | 96 +++++++++
 tb/tb_bcd_serial_addsub.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, FSM states, constants and nines-complement helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_SIX = 4'd6;
  function automatic bcd_digit_t nines_comp(bcd_digit_t d);
    return BCD_NINE - d;
  endfunction
endpackage

// File: rtl/bcd_digit_stage.sv
// bcd_digit_stage: combinational single-digit BCD adder with +6 decimal correction
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  bcd_digit_t da,
  input  bcd_digit_t db,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [4:0] raw;
  always_comb begin
    raw = {1'b0, da} + {1'b0, db} + {4'b0, cin};
    cout = raw > {1'b0, BCD_NINE};
    sum = cout ? raw[3:0] + BCD_SIX : raw[3:0];
  end
endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial packed-BCD add/sub sequencer, optional BCD_CHECK_EN operand check
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*DIGITS-1:0] result,
`ifdef BCD_CHECK_EN
  output logic                err,
`endif
  output logic                carry
);
  localparam int W = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, b_in;
  logic [W+3:0] sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, accept, run, cout;
  bcd_digit_t sum;
`ifdef BCD_CHECK_EN
  logic err_q, err_d, bad;
`endif
  bcd_digit_stage u_stage (
    .da  (a_q[3:0]),
    .db  (b_q[3:0]),
    .cin (c_q),
    .sum (sum),
    .cout(cout)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
`ifdef BCD_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
`ifdef BCD_CHECK_EN
      err_q <= err_d;
`endif
    end
  always_comb begin
    state_d = (state_q == IDLE && start_valid) ? RUN :
              (state_q == RUN && cnt_q == CW'(DIGITS - 1)) ? DONE :
              (state_q == DONE && res_ready) ? IDLE : state_q;
  end
  always_comb begin
    accept = start_valid && state_q == IDLE;
    run = state_q == RUN;
    b_in = b;
    for (int i = 0; i < DIGITS; i++) b_in[4*i+:4] = sub ? nines_comp(b[4*i+:4]) : b[4*i+:4];
    sh = {sum, res_q};
    a_d = accept ? a : run ? a_q >> 4 : a_q;
    b_d = accept ? b_in : run ? b_q >> 4 : b_q;
    c_d = accept ? sub : run ? cout : c_q;
    cnt_d = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    res_d = run ? sh[W+3:4] : res_q;
`ifdef BCD_CHECK_EN
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (a[4*i+:4] > BCD_NINE) | (b[4*i+:4] > BCD_NINE);
    err_d = accept ? bad : err_q;
`endif
  end
  always_comb begin
    start_ready = state_q == IDLE;
    res_valid = state_q == DONE;
`ifdef BCD_CHECK_EN
    err = err_q;
    result = err_q ? '0 : res_q;
    carry = !err_q && c_q;
`else
    result = res_q;
    carry = c_q;
`endif
  end
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb_bcd_serial_addsub: scoreboard bench for bcd_serial_addsub, BCD_CHECK_EN adds err checks
module tb_bcd_serial_addsub;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  localparam int MOD = 10000;
  typedef struct {
    logic [W-1:0] r;
    logic c;
    logic e;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, sub = 1'b0, res_ready = 1'b0;
  logic start_ready, res_valid, carry;
  logic [W-1:0] a = '0, b = '0, result;
`ifdef BCD_CHECK_EN
  logic err;
`endif
  int total = 0, bad = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .sub(sub),
    .a(a),
    .b(b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .result(result),
`ifdef BCD_CHECK_EN
    .err(err),
`endif
    .carry(carry)
  );
  function automatic int bcd2int(logic [W-1:0] v);
    int s = 0;
    for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + int'(v[4*i+:4]);
    return s;
  endfunction
  function automatic logic [W-1:0] int2bcd(int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic s);
    exp_t e;
    int d;
    e.e = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (x[4*i+:4] > 4'd9 || y[4*i+:4] > 4'd9) e.e = 1'b1;
    d = s ? bcd2int(x) - bcd2int(y) : bcd2int(x) + bcd2int(y);
    e.c = e.e ? 1'b0 : s ? (d >= 0) : (d >= MOD);
    e.r = e.e ? '0 : int2bcd(d < 0 ? d + MOD : d % MOD);
    return e;
  endfunction
  task automatic issue(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    total++;
    if (start_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s start_ready before accept got %b want 1", name, start_ready);
    end
    a = x;
    b = y;
    sub = s;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask
  task automatic collect(input string name, input int hold);
    int lat = 0;
    exp_t e;
    while (res_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    total++;
    if (lat != DIGITS) begin
      bad++;
      $display("FAIL %s latency got %0d want %0d", name, lat, DIGITS);
    end
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      a = 16'h1111;
      b = 16'h2222;
      start_valid = 1'b1;
      @(posedge clk);
      #1 total++;
      if (result !== e.r || res_valid !== 1'b1 || start_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s hold%0d result=%h valid=%b ready=%b want %h 1 0", name, k, result, res_valid, start_ready, e.r);
      end
    end
    start_valid = 1'b0;
    total++;
    if (result !== e.r) begin
      bad++;
      $display("FAIL %s result got %h want %h", name, result, e.r);
    end
    total++;
    if (carry !== e.c) begin
      bad++;
      $display("FAIL %s carry got %b want %b", name, carry, e.c);
    end
`ifdef BCD_CHECK_EN
    total++;
    if (err !== e.e) begin
      bad++;
      $display("FAIL %s err got %b want %b", name, err, e.e);
    end
`endif
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s release ready=%b valid=%b want 1 0", name, start_ready, res_valid);
    end
  endtask
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
    sb.push_back(model(x, y, s));
    issue(name, x, y, s);
    collect(name, hold);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 total++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || carry !== 1'b0) begin
      bad++;
      $display("FAIL reset ready=%b valid=%b result=%h carry=%b want 1 0 0000 0", start_ready, res_valid, result, carry);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_add();
    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 0);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 0);
    run_op("add_0000_0000", 16'h0000, 16'h0000, 1'b0, 0);
    run_op("add_9999_9999", 16'h9999, 16'h9999, 1'b0, 0);
  endtask
  task automatic test_sub();
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 0);
    run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 0);
    run_op("sub_4321_4321", 16'h4321, 16'h4321, 1'b1, 0);
    run_op("sub_0100_9999", 16'h0100, 16'h9999, 1'b1, 0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_op("b2b_rand", int2bcd(int'($urandom_range(0, MOD - 1))), int2bcd(int'($urandom_range(0, MOD - 1))), 1'($urandom_range(0, 1)), 0);
  endtask
  task automatic test_backpressure();
    run_op("bp_0042_0058", 16'h0042, 16'h0058, 1'b0, 5);
    @(posedge clk);
    #1 total++;
    if (start_ready !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_no_accept ready=%b pending=%0d want 1 0", start_ready, sb.size());
    end
  endtask
  task automatic test_reset_mid_run();
    issue("rst_mid", 16'h1234, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 total++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1 || result !== '0 || carry !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid valid=%b ready=%b result=%h carry=%b want 0 1 0000 0", res_valid, start_ready, result, carry);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 run_op("add_0500_0500", 16'h0500, 16'h0500, 1'b0, 0);
  endtask
`ifdef BCD_CHECK_EN
  task automatic test_bcd_check();
    run_op("chk_12a4_0001", 16'h12A4, 16'h0001, 1'b0, 0);
    run_op("chk_clear", 16'h0007, 16'h0008, 1'b0, 0);
    run_op("chk_sub_b", 16'h0005, 16'h00F0, 1'b1, 0);
  endtask
`endif
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef BCD_CHECK_EN
    test_bcd_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
